// File: rtl/nn_pkg.sv
// Shared types and helpers for the sequential dense layer: activation select,
// width helpers, controller states and the hard-sigmoid transfer function.
package nn_pkg;

  typedef enum logic {RELU = 1'b0, SIGMOID = 1'b1} activation_type;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_ACT  = 2'd2,
    ST_DONE = 2'd3
  } layer_state_t;

  localparam int HS_W = 64;

  function automatic int acc_width(input int data_width, input int num_inputs);
    return 2 * data_width + $clog2(num_inputs) + 1;
  endfunction

  function automatic int param_addr_width(input int num_neurons, input int num_inputs);
    return $clog2(num_neurons * (num_inputs + 1));
  endfunction

  // Counter width that never collapses to zero bits for a count of one.
  function automatic int idx_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  // y = x/4 + 0.5 in Q(frac_bits), clamped to [0, 1.0].
  function automatic logic signed [HS_W-1:0] hard_sigmoid(input logic signed [HS_W-1:0] x,
                                                          input int frac_bits);
    logic signed [HS_W-1:0] one;
    logic signed [HS_W-1:0] y;
    one = 64'sd1 <<< frac_bits;
    y   = (x >>> 2) + (one >>> 1);
    if (y < 0) begin
      y = '0;
    end else if (y > one) begin
      y = one;
    end
    return y;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// One MAC lane: accumulates products, then bias-add / rescale / narrow / activate
// combinationally. DENSE_LAYER_SEQ_SATURATE_EN selects saturating narrowing (else wrap).
module mac_unit
  import nn_pkg::*;
#(
  parameter int             DATA_WIDTH = 16,
  parameter int             FRAC_BITS  = 8,
  parameter int             ACC_WIDTH  = 37,
  parameter activation_type ACTIVATION = RELU
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear_i,
  input  logic                         enable_i,
  input  logic signed [DATA_WIDTH-1:0] x_i,
  input  logic signed [DATA_WIDTH-1:0] w_i,
  input  logic signed [DATA_WIDTH-1:0] bias_i,
  output logic signed [DATA_WIDTH-1:0] result_o
);

  localparam logic signed [ACC_WIDTH-1:0] MAX_V =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MIN_V =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic signed [2*DATA_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0]    biased, shifted;
  logic signed [DATA_WIDTH-1:0]   narrowed;
  logic                           unused_shift_bits;

  assign product = x_i * w_i;

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (enable_i) begin
      acc_d = acc_q + ACC_WIDTH'(product);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Bias is in the input Q format, so align it with the doubled-fraction product sum.
  assign biased  = acc_q + (ACC_WIDTH'(bias_i) <<< FRAC_BITS);
  assign shifted = biased >>> FRAC_BITS;
  assign unused_shift_bits = ^shifted;

`ifdef DENSE_LAYER_SEQ_SATURATE_EN
  always_comb begin
    narrowed = shifted[DATA_WIDTH-1:0];
    if (shifted > MAX_V) begin
      narrowed = MAX_V[DATA_WIDTH-1:0];
    end else if (shifted < MIN_V) begin
      narrowed = MIN_V[DATA_WIDTH-1:0];
    end
  end
`else
  assign narrowed = shifted[DATA_WIDTH-1:0];
`endif

  always_comb begin
    if (ACTIVATION == SIGMOID) begin
      result_o = DATA_WIDTH'(hard_sigmoid(HS_W'(narrowed), FRAC_BITS));
    end else begin
      result_o = narrowed[DATA_WIDTH-1] ? '0 : narrowed;
    end
  end

endmodule

// File: rtl/dense_layer_seq.sv
// Sequential dense layer: NUM_UNITS MAC lanes sweep neuron groups; valid (NG*(NI+1)+1) cycles
// after input handshake, results held in DONE until outputs_ready. Narrowing: DENSE_LAYER_SEQ_SATURATE_EN.
module dense_layer_seq
  import nn_pkg::*;
#(
  parameter int             DATA_WIDTH  = 16,
  parameter int             FRAC_BITS   = 8,
  parameter int             NUM_INPUTS  = 16,
  parameter int             NUM_NEURONS = 16,
  parameter int             NUM_UNITS   = 4,
  parameter activation_type ACTIVATION  = RELU,
  localparam int            PW          = param_addr_width(NUM_NEURONS, NUM_INPUTS)
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic                                         inputs_valid,
  output logic                                         inputs_ready,
  input  logic signed [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  inputs,
  input  logic                                         param_write,
  input  logic        [PW-1:0]                         param_address,
  input  logic signed [DATA_WIDTH-1:0]                 param_data,
  output logic                                         param_ready,
  output logic signed [NUM_NEURONS-1:0][DATA_WIDTH-1:0] outputs,
  output logic                                         outputs_valid,
  input  logic                                         outputs_ready
);

  localparam int NUM_PARAMS = NUM_NEURONS * (NUM_INPUTS + 1);
  localparam int NUM_GROUPS = NUM_NEURONS / NUM_UNITS;
  localparam int ACC_W      = acc_width(DATA_WIDTH, NUM_INPUTS);
  localparam int IDX_W      = idx_width(NUM_INPUTS);
  localparam int GRP_W      = idx_width(NUM_GROUPS);
  localparam int OIDX_W     = idx_width(NUM_NEURONS);
  localparam logic [PW:0]      NUM_PARAMS_W = (PW+1)'(NUM_PARAMS);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_INPUTS - 1);
  localparam logic [GRP_W-1:0] LAST_GRP     = GRP_W'(NUM_GROUPS - 1);

  if (NUM_NEURONS % NUM_UNITS != 0) begin : g_bad_units
    $error("NUM_NEURONS must be divisible by NUM_UNITS");
  end
  if (FRAC_BITS < 0 || FRAC_BITS > DATA_WIDTH - 2) begin : g_bad_frac
    $error("FRAC_BITS must lie in 0..DATA_WIDTH-2");
  end

  layer_state_t                               state_q;
  logic         [GRP_W-1:0]                   group_q;
  logic         [IDX_W-1:0]                   index_q;
  logic         [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  inputs_q;
  logic         [NUM_NEURONS-1:0][DATA_WIDTH-1:0] outputs_q;
  logic                                       inputs_ready_q;
  logic                                       param_ready_q;
  logic                                       outputs_valid_q;
  logic signed  [DATA_WIDTH-1:0]              param_q [NUM_PARAMS];
  logic signed  [DATA_WIDTH-1:0]              unit_result [NUM_UNITS];
  logic signed  [DATA_WIDTH-1:0]              x_cur;
  logic                                       acc_clear;
  logic                                       acc_enable;

  assign inputs_ready  = inputs_ready_q;
  assign param_ready   = param_ready_q;
  assign outputs_valid = outputs_valid_q;
  assign outputs       = outputs_q;

  // A write in the handshake cycle lands on this edge, ahead of the first MAC read.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_PARAMS; i++) begin
        param_q[i] <= '0;
      end
    end else if (param_write && param_ready_q && ({1'b0, param_address} < NUM_PARAMS_W)) begin
      param_q[param_address] <= param_data;
    end
  end

  assign x_cur      = $signed(inputs_q[index_q]);
  assign acc_clear  = (state_q == ST_IDLE) || (state_q == ST_ACT);
  assign acc_enable = (state_q == ST_MAC);

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
    logic [PW-1:0] w_addr;
    logic [PW-1:0] b_addr;

    assign w_addr = PW'((int'(group_q) * NUM_UNITS + u) * (NUM_INPUTS + 1) + int'(index_q));
    assign b_addr = PW'((int'(group_q) * NUM_UNITS + u) * (NUM_INPUTS + 1) + NUM_INPUTS);

    mac_unit #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .ACC_WIDTH  (ACC_W),
      .ACTIVATION (ACTIVATION)
    ) u_mac (
      .clock    (clock),
      .reset    (reset),
      .clear_i  (acc_clear),
      .enable_i (acc_enable),
      .x_i      (x_cur),
      .w_i      (param_q[w_addr]),
      .bias_i   (param_q[b_addr]),
      .result_o (unit_result[u])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      group_q         <= '0;
      index_q         <= '0;
      inputs_q        <= '0;
      outputs_q       <= '0;
      inputs_ready_q  <= 1'b1;
      param_ready_q   <= 1'b1;
      outputs_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (inputs_valid && inputs_ready_q) begin
            inputs_q       <= inputs;
            group_q        <= '0;
            index_q        <= '0;
            inputs_ready_q <= 1'b0;
            param_ready_q  <= 1'b0;
            state_q        <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (index_q == LAST_IDX) begin
            index_q <= '0;
            state_q <= ST_ACT;
          end else begin
            index_q <= index_q + IDX_W'(1);
          end
        end
        ST_ACT: begin
          for (int u = 0; u < NUM_UNITS; u++) begin
            outputs_q[OIDX_W'(int'(group_q) * NUM_UNITS + u)] <= unit_result[u];
          end
          if (group_q == LAST_GRP) begin
            outputs_valid_q <= 1'b1;
            param_ready_q   <= 1'b1;
            state_q         <= ST_DONE;
          end else begin
            group_q <= group_q + GRP_W'(1);
            state_q <= ST_MAC;
          end
        end
        ST_DONE: begin
          if (outputs_ready) begin
            outputs_valid_q <= 1'b0;
            inputs_ready_q  <= 1'b1;
            state_q         <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Scoreboarded bench: a RELU and a SIGMOID instance share stimulus; expectations come
// from an integer reference of the layer equation and are checked by an output monitor.
module tb_dense_layer_seq;
  import nn_pkg::*;

  localparam int DW  = 16;
  localparam int FB  = 8;
  localparam int NI  = 16;
  localparam int NN  = 16;
  localparam int NU  = 4;
  localparam int NP  = NN * (NI + 1);
  localparam int AW  = $clog2(NP);
  localparam int LAT = (NN / NU) * (NI + 1) + 1;
  localparam longint MAXV = (longint'(1) <<< (DW - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (DW - 1));

  typedef logic [NN-1:0][DW-1:0] vec_t;
  typedef struct packed {
    vec_t relu;
    vec_t sig;
  } exp_t;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  inputs_valid;
  logic                  outputs_ready;
  logic                  param_write;
  logic [AW-1:0]         param_address;
  logic signed [DW-1:0]  param_data;
  logic [NI-1:0][DW-1:0] inputs;
  logic                  inputs_ready_r, inputs_ready_s;
  logic                  param_ready_r, param_ready_s;
  logic                  valid_r, valid_s;
  vec_t                  out_r, out_s;

  int     w_m [NN][NI+1];
  int     in_m [NI];
  exp_t   exp_q [$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     hs_cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  dense_layer_seq #(.ACTIVATION(RELU)) u_relu (
    .clock(clock), .reset(reset), .inputs_valid(inputs_valid), .inputs_ready(inputs_ready_r),
    .inputs(inputs), .param_write(param_write), .param_address(param_address),
    .param_data(param_data), .param_ready(param_ready_r), .outputs(out_r),
    .outputs_valid(valid_r), .outputs_ready(outputs_ready)
  );

  dense_layer_seq #(.ACTIVATION(SIGMOID)) u_sig (
    .clock(clock), .reset(reset), .inputs_valid(inputs_valid), .inputs_ready(inputs_ready_s),
    .inputs(inputs), .param_write(param_write), .param_address(param_address),
    .param_data(param_data), .param_ready(param_ready_s), .outputs(out_s),
    .outputs_valid(valid_s), .outputs_ready(outputs_ready)
  );

  task automatic check_val(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_vec(input string name, input vec_t act, input vec_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // out[n] = act(narrow((sum_k in[k]*w[n][k] + bias[n]*2^FB) / 2^FB)), division flooring.
  function automatic vec_t model(input bit sig);
    vec_t r;
    longint acc;
    logic signed [DW-1:0] n16;
    int v, y;
    r = '0;
    for (int n = 0; n < NN; n++) begin
      acc = 0;
      for (int k = 0; k < NI; k++) acc += longint'(in_m[k]) * longint'(w_m[n][k]);
      acc += longint'(w_m[n][NI]) * (longint'(1) <<< FB);
      acc = acc >>> FB;
`ifdef DENSE_LAYER_SEQ_SATURATE_EN
      if (acc > MAXV) acc = MAXV;
      else if (acc < MINV) acc = MINV;
`endif
      n16 = acc[DW-1:0];
      v = int'(n16);
      if (sig) begin
        y = (v >>> 2) + (1 <<< (FB - 1));
        if (y < 0) y = 0;
        else if (y > (1 <<< FB)) y = 1 <<< FB;
      end else begin
        y = (v < 0) ? 0 : v;
      end
      r[n] = DW'(y);
    end
    return r;
  endfunction

  function automatic int rnd(input int lo, input int hi);
    return lo + int'($urandom_range(hi - lo));
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int addr, input int data);
    param_write   = 1'b1;
    param_address = AW'(addr);
    param_data    = DW'(data);
    step();
    param_write   = 1'b0;
  endtask

  task automatic load_params();
    for (int n = 0; n < NN; n++)
      for (int k = 0; k <= NI; k++) wr(n * (NI + 1) + k, w_m[n][k]);
  endtask

  task automatic set_all(input int w, input int b);
    for (int n = 0; n < NN; n++) begin
      for (int k = 0; k < NI; k++) w_m[n][k] = w;
      w_m[n][NI] = b;
    end
  endtask

  task automatic set_rand(input int wlo, input int whi);
    for (int n = 0; n < NN; n++)
      for (int k = 0; k <= NI; k++) w_m[n][k] = rnd(wlo, whi);
  endtask

  task automatic send(input bit push, input bit hs_wr, input int hs_addr, input int hs_data);
    exp_t e;
    int t;
    for (int i = 0; i < NI; i++) inputs[i] = DW'(in_m[i]);
    inputs_valid = 1'b1;
    t = 0;
    while (!inputs_ready_r && t < 300) begin
      step();
      t++;
    end
    if (!inputs_ready_r) begin
      check_val("handshake_timeout", 0, 1);
      inputs_valid = 1'b0;
      return;
    end
    hs_cyc = cyc;
    if (hs_wr) begin
      param_write   = 1'b1;
      param_address = AW'(hs_addr);
      param_data    = DW'(hs_data);
      w_m[hs_addr / (NI + 1)][hs_addr % (NI + 1)] = hs_data;
    end
    if (push) begin
      e.relu = model(1'b0);
      e.sig  = model(1'b1);
      exp_q.push_back(e);
    end
    step();
    inputs_valid = 1'b0;
    param_write  = 1'b0;
    for (int i = 0; i < NI; i++) inputs[i] = DW'($urandom);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 400) begin
      step();
      t++;
    end
    if (exp_q.size() > 0) begin
      check_val("result_timeout", longint'(exp_q.size()), 0);
      exp_q.delete();
    end
    step();
  endtask

  initial begin : monitor
    exp_t e;
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clock);
      if (valid_r && !prev_valid) check_val("latency", longint'(cyc - hs_cyc), LAT);
      if (valid_r && outputs_ready) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_vec("relu_outputs", out_r, e.relu);
          check_vec("sigmoid_outputs", valid_s ? out_s : ~out_s, e.sig);
        end
      end
      prev_valid = valid_r;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    vec_t snap;
    bit stable;
    int t;
    reset = 1'b1; inputs_valid = 1'b0; outputs_ready = 1'b1;
    param_write = 1'b0; param_address = '0; param_data = '0; inputs = '0;
    set_all(0, 0);
    for (int i = 0; i < NI; i++) in_m[i] = 0;
    repeat (3) step();
    reset = 1'b0;
    step();

    check_val("reset_inputs_ready", longint'(inputs_ready_r & inputs_ready_s), 1);
    check_val("reset_param_ready", longint'(param_ready_r & param_ready_s), 1);
    check_val("reset_outputs_valid", longint'(valid_r | valid_s), 0);
    check_vec("reset_outputs_relu", out_r, '0);
    check_vec("reset_outputs_sig", out_s, '0);

    // Parameters cleared by reset: relu gives 0, sigmoid gives 0.5.
    for (int i = 0; i < NI; i++) in_m[i] = rnd(-1024, 1023);
    send(1, 0, 0, 0); wait_done();

    set_all(256, 0); load_params();
    for (int i = 0; i < NI; i++) in_m[i] = 128;
    send(1, 0, 0, 0); wait_done();
    check_val("ones_times_half", longint'($signed(out_r[7])), 2048);

    set_all(-256, 0); load_params();
    for (int i = 0; i < NI; i++) in_m[i] = 256;
    send(1, 0, 0, 0); wait_done();

    set_all(0, 0);
    for (int n = 0; n < NN; n++) w_m[n][0] = 256;
    load_params();
    for (int i = 0; i < NI; i++) in_m[i] = 0;
    foreach (in_m[i]) in_m[i] = 0;
    in_m[0] = 0;     send(1, 0, 0, 0); wait_done();
    check_val("sigmoid_x0", longint'(out_s[3]), 128);
    in_m[0] = -1024; send(1, 0, 0, 0); wait_done();
    check_val("sigmoid_xm4", longint'(out_s[3]), 0);
    in_m[0] = 1024;  send(1, 0, 0, 0); wait_done();
    check_val("sigmoid_xp4", longint'(out_s[3]), 256);

    set_all(32512, 0); load_params();
    for (int i = 0; i < NI; i++) in_m[i] = 32512;
    send(1, 0, 0, 0); wait_done();

    for (int r = 0; r < 3; r++) begin
      set_rand(-512, 511); load_params();
      for (int i = 0; i < NI; i++) in_m[i] = rnd(-1024, 1023);
      send(1, 0, 0, 0); wait_done();
    end
    set_rand(-32768, 32767); load_params();
    for (int i = 0; i < NI; i++) in_m[i] = rnd(-32768, 32767);
    send(1, 0, 0, 0); wait_done();

    // Out-of-range writes are ignored; a bias write in the handshake cycle counts.
    set_rand(-512, 511); load_params();
    wr(NP, 1000); wr(NP + 100, -1000);
    for (int i = 0; i < NI; i++) in_m[i] = rnd(-1024, 1023);
    send(1, 1, 3 * (NI + 1) + NI, 300); wait_done();

    // Backpressure in DONE plus writes dropped during MAC.
    outputs_ready = 1'b0;
    for (int i = 0; i < NI; i++) in_m[i] = rnd(-1024, 1023);
    send(1, 0, 0, 0);
    step();
    check_val("param_ready_in_mac", longint'(param_ready_r), 0);
    wr(0, 9999); wr(5 * (NI + 1) + NI, 5000);
    t = 0;
    while (!valid_r && t < 200) begin step(); t++; end
    check_val("valid_under_backpressure", longint'(valid_r), 1);
    snap = out_r;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (out_r !== snap || !valid_r || inputs_ready_r) stable = 1'b0;
    end
    check_val("held_in_done", longint'(stable), 1);
    check_val("param_ready_in_done", longint'(param_ready_r), 1);
    outputs_ready = 1'b1;
    wait_done();

    // Reset during MAC at index 5 abandons the run and clears parameters.
    for (int i = 0; i < NI; i++) in_m[i] = rnd(-1024, 1023);
    send(0, 0, 0, 0);
    t = 0;
    while (cyc < hs_cyc + 6 && t < 50) begin step(); t++; end
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    check_val("abandon_valid", longint'(valid_r), 0);
    check_vec("abandon_outputs", out_r, '0);
    check_val("abandon_ready", longint'(inputs_ready_r), 1);
    set_all(0, 0);
    set_rand(-512, 511); load_params();
    for (int i = 0; i < NI; i++) in_m[i] = rnd(-1024, 1023);
    send(1, 0, 0, 0); wait_done();

    repeat (5) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
